sfifo_param: RTL and testbench

SFIFO_PARAM -- requirements
Module: sfifo_param

---
 rtl/sfifo_param.sv | 118 +++++++++++
 tb/tb_sfifo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_param.sv
// sfifo_param: single-clock synchronous FIFO with registered read data,
// occupancy count, almost-full/almost-empty thresholds and optional sticky
// overflow/underflow error flags (enabled by defining SFIFO_ERR_FLAGS_EN).
module sfifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w_en,
   input  logic                     r_en,
   input  logic [DATA_W-1:0]        data_in,
   output logic [DATA_W-1:0]        data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_LVL  = CNT_W'(AE_THRESH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_data_out;

   logic w_wr_accept;
   logic w_rd_accept;
   logic w_full;
   logic w_empty;

   // Status flags are pure decodes of the registered count.
   assign w_full  = (r_count == CNT_MAX);
   assign w_empty = (r_count == '0);

   // A request is accepted only when the FIFO can honour it.
   assign w_wr_accept = w_en & ~w_full;
   assign w_rd_accept = r_en & ~w_empty;

   // Storage array: written on accepted writes only.
   // NOTE: the memory has no reset; pointers and count define which words are valid.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_accept) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers, occupancy count and registered read data.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_accept) begin
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            r_data_out <= r_mem[r_rd_ptr];
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef SFIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags: set on a rejected request, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (r_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   assign data_out     = r_data_out;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= AF_LVL);
   assign almost_empty = (r_count <= AE_LVL);

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed and randomized stimulus for sfifo_param, checked
// every cycle against a queue-based reference model of the FIFO.
module tb_sfifo_param;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 16;
   localparam int AF_THRESH = 14;
   localparam int AE_THRESH = 2;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic              w_en;
   logic              r_en;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   sfifo_param #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .w_en         (w_en),
      .r_en         (r_en),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [DATA_W-1:0] model_q[$];
   logic [DATA_W-1:0] exp_dout;
   logic              exp_ovf;
   logic              exp_unf;
   logic [DATA_W-1:0] read_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic check_all(input string tag);
      int n;
      n = model_q.size();
      check({tag, ":count"},    32'(count),        32'(n));
      check({tag, ":empty"},    32'(empty),        32'(n == 0));
      check({tag, ":full"},     32'(full),         32'(n == DEPTH));
      check({tag, ":afull"},    32'(almost_full),  32'(n >= AF_THRESH));
      check({tag, ":aempty"},   32'(almost_empty), 32'(n <= AE_THRESH));
      check({tag, ":dout"},     32'(data_out),     32'(exp_dout));
      check({tag, ":overflow"}, 32'(overflow),     32'(exp_ovf));
      check({tag, ":underflow"},32'(underflow),    32'(exp_unf));
   endtask

   // Apply one cycle of stimulus, advance the model, then check outputs.
   task automatic step(input logic rst, input logic w, input logic r,
                       input logic [DATA_W-1:0] d, input string tag);
      int  n;
      bit  wa;
      bit  ra;
      reset   = rst;
      w_en    = w;
      r_en    = r;
      data_in = d;
      n = model_q.size();
      if (rst) begin
         model_q.delete();
         exp_dout = '0;
         exp_ovf  = 1'b0;
         exp_unf  = 1'b0;
      end else begin
         wa = w && (n != DEPTH);
         ra = r && (n != 0);
`ifdef SFIFO_ERR_FLAGS_EN
         if (w && n == DEPTH) exp_ovf = 1'b1;
         if (r && n == 0)     exp_unf = 1'b1;
`endif
         if (ra) begin
            exp_dout = model_q.pop_front();
            read_log.push_back(exp_dout);
         end
         if (wa) model_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int next_val;
      int guard;
      reset   = 1'b0;
      w_en    = 1'b0;
      r_en    = 1'b0;
      data_in = '0;
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;

      // Reset for two cycles
      step(1'b1, 1'b0, 1'b0, 8'h00, "reset0");
      step(1'b1, 1'b0, 1'b0, 8'h00, "reset1");

      // Basic write 1..4 then read 4
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 8'(i), "wr1to4");
      for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 1'b1, 8'h00, "rd1to4");
      check("basic:order", 32'({read_log[0], read_log[1], read_log[2], read_log[3]}), 32'h01020304);
      step(1'b0, 1'b0, 1'b0, 8'h00, "idle_hold");

      // Fill with 0x10..0x1F, then one write while full
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), "fill");
      step(1'b0, 1'b1, 1'b0, 8'hEE, "write_full");

      // Full with simultaneous write/read: read wins, 0xAA rejected
      step(1'b0, 1'b1, 1'b1, 8'hAA, "full_wr_rd");
      check("full_wr_rd:dout10", 32'(data_out), 32'h10);

      // Drain completely, checking 0xAA never appears
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
      check("drain:last", 32'(data_out), 32'h1F);

      // Empty with simultaneous write/read: write wins, data_out holds
      step(1'b0, 1'b1, 1'b1, 8'h55, "empty_wr_rd");
      step(1'b0, 1'b0, 1'b1, 8'h00, "read55");
      check("read55:dout", 32'(data_out), 32'h55);
      step(1'b0, 1'b0, 1'b1, 8'h00, "read_empty");

      // Clear error flags, then 40 values with random interleaving
      step(1'b1, 1'b0, 1'b0, 8'h00, "reset_mid");
      read_log.delete();
      next_val = 0;
      guard = 0;
      while (next_val < 40 && guard < 1000) begin
         bit w;
         bit r;
         w = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 1) != 0);
         if (w && model_q.size() != DEPTH) begin
            step(1'b0, 1'b1, r, 8'(next_val), "wrap_mix");
            next_val++;
         end else begin
            step(1'b0, w, r, 8'(next_val), "wrap_mix");
         end
         guard++;
      end
      check("wrap:all_written", 32'(next_val), 32'd40);
      guard = 0;
      while (model_q.size() != 0 && guard < 100) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, "wrap_drain");
         guard++;
      end
      check("wrap:read_count", 32'(read_log.size()), 32'd40);
      for (int i = 0; i < read_log.size() && i < 40; i++) begin
         check("wrap:order", 32'(read_log[i]), 32'(i));
      end

      // Reset with seven words stored
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), "fill7");
      step(1'b0, 1'b0, 1'b1, 8'h00, "read_one");
      step(1'b0, 1'b1, 1'b0, 8'hC7, "fill7b");
      check("pre_reset:count7", 32'(count), 32'd7);
      step(1'b1, 1'b1, 1'b1, 8'h99, "reset_count7");

      // Fully random traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) != 0),
              ($urandom_range(0, 1) != 0), 8'($urandom), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
